// File: rtl/mk_fifo_pkg.sv
// Shared sizing helpers for the mk_fifo library: the ceil-log2 constant function
// and the zero-width-safe MSB index used to size data vectors.
package mk_fifo_pkg;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r++;
    end
    return r;
  endfunction

  // MSB index for a vector of w bits; a zero-width field degrades to one unused bit.
  function automatic int unsigned zw_msb(input int unsigned w);
    return (w == 0) ? 0 : w - 1;
  endfunction

  // Pointer width for a ring of the given depth; at least one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mk_fifo_ptr.sv
// Wrap-around ring pointer: counts 0..Depth-1 and wraps by explicit compare, so
// Depth need not be a power of two.
module mk_fifo_ptr
  import mk_fifo_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = ptr_width(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] ptr_o
);

  localparam logic [Width-1:0] Last = Width'(Depth - 1);

  logic [Width-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == Last) ? '0 : ptr_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/mk_fifo.sv
// Synchronous circular-buffer FIFO with registered full/empty, synchronous clear
// and sticky overflow/underflow flags. All outputs come from registered state.
module mk_fifo
  import mk_fifo_pkg::*;
#(
  parameter int unsigned width = 1,
  parameter int unsigned depth = 2
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [zw_msb(width):0]     IN_ENQ_WRITE,
  input  logic                       IN_EN_ENQ_WRITE,
  output logic                       OUT_ENQ_READ,
  output logic [zw_msb(width):0]     OUT_FIRST_READ,
  output logic                       OUT_DEQ_READ,
  input  logic                       IN_EN_DEQ_WRITE,
  input  logic                       IN_EN_CLEAR_WRITE,
  output logic [clog2(depth+1)-1:0]  OUT_COUNT_READ,
  output logic                       OUT_OVERFLOW_READ,
  output logic                       OUT_UNDERFLOW_READ
);

  localparam int unsigned DataW = zw_msb(width) + 1;
  localparam int unsigned PtrW  = ptr_width(depth);
  localparam int unsigned CntW  = clog2(depth + 1);

  logic [PtrW-1:0]  head, tail;
  logic [CntW-1:0]  count_q, count_d;
  logic [DataW-1:0] mem_q [depth];
  logic [DataW-1:0] first;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             full, empty, clear, enq_ok, deq_ok;

  assign full   = (count_q == CntW'(depth));
  assign empty  = (count_q == '0);
  assign clear  = IN_EN_CLEAR_WRITE;
  // Acceptance is judged on registered occupancy only: no full-bypass.
  assign enq_ok = IN_EN_ENQ_WRITE && !full && !clear;
  assign deq_ok = IN_EN_DEQ_WRITE && !empty && !clear;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      unique case ({enq_ok, deq_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    ovf_d = clear ? 1'b0 : (ovf_q | (IN_EN_ENQ_WRITE & full));
    unf_d = clear ? 1'b0 : (unf_q | (IN_EN_DEQ_WRITE & empty));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  mk_fifo_ptr #(
    .Depth (depth),
    .Width (PtrW)
  ) u_head (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (clear),
    .inc_i  (deq_ok),
    .ptr_o  (head)
  );

  mk_fifo_ptr #(
    .Depth (depth),
    .Width (PtrW)
  ) u_tail (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (clear),
    .inc_i  (enq_ok),
    .ptr_o  (tail)
  );

  // Storage survives clear and dequeue; only reset zeroes it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < depth; i++) begin
        if (enq_ok && (tail == PtrW'(i))) begin
          mem_q[i] <= IN_ENQ_WRITE;
        end
      end
    end
  end

  always_comb begin
    first = '0;
    for (int unsigned i = 0; i < depth; i++) begin
      if (head == PtrW'(i)) begin
        first = mem_q[i];
      end
    end
  end

  assign OUT_ENQ_READ       = !full;
  assign OUT_DEQ_READ       = !empty;
  assign OUT_FIRST_READ     = first;
  assign OUT_COUNT_READ     = count_q;
  assign OUT_OVERFLOW_READ  = ovf_q;
  assign OUT_UNDERFLOW_READ = unf_q;

endmodule
